// File: rtl/mem_bus_ctrl.sv
// External memory bus controller: turns single-cycle requests into timed
// strobe sequences with wait states, n_rdy stretching and timeout reporting.
module mem_bus_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe,
    output logic              n_oe,
    output logic              n_we,
    input  logic              n_rdy,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [CNT_W:0] MIN_C = (CNT_W+1)'(MIN_WAIT);
    localparam logic [CNT_W:0] TO_C  = (CNT_W+1)'(TIMEOUT);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W:0]    cnt_inc;
    logic              we_q, we_n;
    logic              err_q, err_n;
    logic              hs;
    logic              rdy_ok;
    logic              tmo;

    logic              n_oe_d, n_we_d, d_oe_d;
    logic              resp_valid_d, resp_err_d;
    logic              busy_d, ready_d;
    logic [ADDR_W-1:0] a_d;
    logic [DATA_W-1:0] d_out_d, rdata_d;

    assign hs      = req_valid & req_ready;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign rdy_ok  = (cnt_inc >= MIN_C) && !n_rdy;
    assign tmo     = (TIMEOUT != 0) && (cnt_inc == TO_C) && !rdy_ok;

    // State and every bus-facing output are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            a          <= '0;
            d_out      <= '0;
            d_oe       <= 1'b0;
            n_oe       <= 1'b1;
            n_we       <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            we_q       <= we_n;
            err_q      <= err_n;
            a          <= a_d;
            d_out      <= d_out_d;
            d_oe       <= d_oe_d;
            n_oe       <= n_oe_d;
            n_we       <= n_we_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= rdata_d;
            busy       <= busy_d;
            req_ready  <= ready_d;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = we_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    state_n = SETUP;
                    we_n    = req_we;
                end
            end
            SETUP: begin
                state_n = STROBE;
                cnt_n   = '0;
            end
            STROBE: begin
                cnt_n = cnt_inc[CNT_W-1:0];
                if (rdy_ok) begin
                    state_n = HOLD;
                end else if (tmo) begin
                    state_n = HOLD;
                    err_n   = 1'b1;
                end
            end
            HOLD: begin
                state_n = IDLE;
                err_n   = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in step with it.
    always_comb begin
        n_oe_d       = !((state_n == STROBE) && !we_n);
        n_we_d       = !((state_n == STROBE) && we_n);
        d_oe_d       = we_n && (state_n != IDLE);
        resp_valid_d = (state_n == HOLD);
        resp_err_d   = (state_n == HOLD) && err_n;
        busy_d       = (state_n != IDLE);
        ready_d      = (state_n == IDLE);
        a_d          = hs ? req_addr : a;
        d_out_d      = hs ? req_wdata : d_out;
        rdata_d      = resp_rdata;
        if ((state == STROBE) && rdy_ok && !we_q) begin
            rdata_d = d_in;
        end
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Parametrised external memory bus controller.
- Sits between the CPU control unit/datapath and the asynchronous-style memory bus (a, d, n_oe, n_we, n_rdy).
- Converts single-cycle read/write requests into a timed strobe sequence: address setup, strobe with programmable minimum wait states and n_rdy stretching, data hold, and one-cycle response.
- Adds timeout/error reporting, which the existing bus handling does not have.

Parameters:
- ADDR_W, 16: address bus width.
- DATA_W, 8: data bus width.
- MIN_WAIT, 1: minimum STROBE cycles per access; must be >= 1.
- TIMEOUT, 255: maximum STROBE cycles before abort; 0 disables timeout; if nonzero, must be >= MIN_WAIT.
- CNT_W, 8: wait counter width; must hold max(MIN_WAIT, TIMEOUT).

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  access address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1 = timed out.
- resp_rdata  out  DATA_W  read data; valid with resp_valid on reads.
- a  out  ADDR_W  memory address.
- d_in  in  DATA_W  memory data bus, input side.
- d_out  out  DATA_W  memory data bus, output side.
- d_oe  out  1  drive d_out onto the bus; the top level builds the tristate.
- n_oe  out  1  active-low memory read strobe.
- n_we  out  1  active-low memory write strobe.
- n_rdy  in  1  active-low memory ready; synchronous to clk, sampled at the rising edge.
- busy  out  1  asserted whenever state != IDLE.

Behaviour:
- All outputs are registered. No combinational path from req_* or n_rdy to the bus outputs.
- Reset values: state=IDLE, a=0, d_out=0, d_oe=0, n_oe=1, n_we=1, resp_valid=0, resp_err=0, resp_rdata=0, busy=0, req_ready=1.
- req_ready = (state==IDLE). Handshake completes at an edge where req_valid & req_ready.
- On the handshake:
  - latch addr, wdata and we;
  - a <= req_addr;
  - d_out <= req_wdata;
  - go to SETUP.
- SETUP, 1 cycle:
  - a is stable; strobes are high.
  - For writes, d_oe=1 from this cycle onward.
  - Next: STROBE, cnt=0.
- STROBE:
  - Read: n_oe=0. Write: n_we=0.
  - Each cycle cnt <= cnt+1.
  - Exit to HOLD at the end of a cycle where (cnt+1 >= MIN_WAIT) and n_rdy==0.
  - On that edge, for reads: resp_rdata <= d_in.
- Timeout:
  - If TIMEOUT != 0, (cnt+1 == TIMEOUT) and the exit condition is false, go to HOLD with the error flag set.
  - resp_rdata is unchanged on a timeout.
- n_rdy before MIN_WAIT is satisfied: ignored.
- Deasserting n_rdy after MIN_WAIT extends STROBE indefinitely, up to TIMEOUT.
- HOLD, 1 cycle:
  - Strobes are high; a and d_out are held; d_oe stays 1 for writes.
  - resp_valid=1; resp_err=error flag.
  - Next: IDLE, with d_oe=0 and the error flag cleared.
- IDLE: a and d_out keep their last values; strobes are high; d_oe=0.
- Latency: the handshake edge at cycle T gives SETUP in T+1, STROBE in T+2..T+1+W, HOLD/resp_valid in T+2+W, and req_ready=1 again in T+3+W.
  - W = max(MIN_WAIT, cycles until n_rdy low), capped at TIMEOUT.
  - Minimum turnaround is 4 cycles per access.
- Back-to-back: a request presented in the first IDLE cycle is accepted immediately; there is no extra bubble.
- req_valid while busy is ignored (req_ready=0). Requesters must hold their request.
- Reset mid-operation: the next cycle shows reset values (strobes high, d_oe=0). No resp_valid is issued for the aborted access.
- n_oe and n_we are never low simultaneously. d_oe=1 is never true while n_oe=0.

Test Plan:
- Read, MIN_WAIT=1, n_rdy tied 0, addr 0x1234, memory returns 0xA5 -> n_oe low exactly 1 cycle (T+2); resp_valid at T+3 with rdata=0xA5, err=0; req_ready at T+4.
- Write 0x3C to 0x8001, n_rdy held high 3 STROBE cycles then low -> n_we low 4 cycles; d_oe=1 from SETUP through HOLD; a=0x8001 stable throughout; resp_valid at T+6, err=0.
- TIMEOUT=4, read with n_rdy stuck high -> n_oe low exactly 4 cycles; resp_valid, err=1; resp_rdata keeps its previous value; controller returns to IDLE.
- MIN_WAIT=3, n_rdy low from the start -> STROBE lasts exactly 3 cycles; early ready is ignored.
- Two reads issued back-to-back with req_valid held high -> the second is accepted on the first IDLE cycle after the first HOLD; 8 cycles total for two accesses; both resp_rdata values are correct.
- rst asserted during a write STROBE -> next cycle n_we=1, d_oe=0, a=0, busy=0; no resp_valid; a following read completes normally.
